// File: rtl/key_pkg.sv
// Shared types and default 50 MHz timing for the pushbutton conditioner.
package key_pkg;

  localparam int unsigned NUM_KEYS_DEF      = 4;
  localparam int unsigned STABLE_CYCLES_DEF = 500000;
  localparam int unsigned LONG_CYCLES_DEF   = 50000000;
  localparam int unsigned CNT_W_DEF         = 26;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_conditioner_if.sv
// Raw KEY inputs and the conditioned per-key levels and strobes.
interface key_conditioner_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] long_pulse;

  modport master (output KEY, input pressed, input press_pulse, input release_pulse, input long_pulse);
  modport slave  (input KEY, output pressed, output press_pulse, output release_pulse, output long_pulse);
endinterface

// File: rtl/key_channel.sv
// One pushbutton: two-flop synchroniser, debounce FSM and long-press timer.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_pulse_o
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT    = CNT_W'(LONG_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic             s_c;
  key_state_e       state_q;
  logic [CNT_W-1:0] dcnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic             pressed_q;
  logic             press_pulse_q;
  logic             release_pulse_q;
  logic             long_pulse_q;

  assign s_c = ~sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      state_q         <= ST_IDLE;
      dcnt_q          <= '0;
      hcnt_q          <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
    end else begin
      sync1_q         <= key_n_i;
      sync2_q         <= sync1_q;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s_c) begin
            state_q <= ST_PRESS_WAIT;
            dcnt_q  <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s_c) begin
            state_q <= ST_IDLE;
          end else if (dcnt_q == STABLE_LAST) begin
            state_q       <= ST_PRESSED;
            pressed_q     <= 1'b1;
            press_pulse_q <= 1'b1;
            hcnt_q        <= '0;
          end else begin
            dcnt_q <= dcnt_q + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          // hcnt parks at LONG_CYCLES so the long strobe fires once per hold
          if (hcnt_q == LONG_LAST) long_pulse_q <= 1'b1;
          if (hcnt_q != LONG_SAT)  hcnt_q <= hcnt_q + CNT_W'(1);
          if (!s_c) begin
            state_q <= ST_RELEASE_WAIT;
            dcnt_q  <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (s_c) begin
            state_q <= ST_PRESSED;
          end else if (dcnt_q == STABLE_LAST) begin
            state_q         <= ST_IDLE;
            pressed_q       <= 1'b0;
            release_pulse_q <= 1'b1;
            hcnt_q          <= '0;
          end else begin
            dcnt_q <= dcnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_pulse_q;
  assign release_pulse_o = release_pulse_q;
  assign long_pulse_o    = long_pulse_q;

endmodule

// File: rtl/key_conditioner.sv
// Array of independent key channels conditioning the DE2 pushbuttons.
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS      = NUM_KEYS_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input logic               CLOCK_50,
  input logic               RESET,
  key_conditioner_if.slave  bus
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .CNT_W         (CNT_W)
    ) u_chan (
      .clk_i           (CLOCK_50),
      .rst_i           (RESET),
      .key_n_i         (bus.KEY[g]),
      .pressed_o       (bus.pressed[g]),
      .press_pulse_o   (bus.press_pulse[g]),
      .release_pulse_o (bus.release_pulse[g]),
      .long_pulse_o    (bus.long_pulse[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed and random checks of key_conditioner against a run-length reference model.
module tb_key_conditioner;

  localparam int unsigned NK = 4;
  localparam int S = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_conditioner_if #(.NUM_KEYS(NK)) bus ();

  key_conditioner #(
    .NUM_KEYS      (NK),
    .STABLE_CYCLES (S),
    .LONG_CYCLES   (L),
    .CNT_W         (8)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: a level flips once the synchronised input has disagreed
  // with it for S+1 consecutive samples; held counts cycles spent settled-pressed.
  logic [NK-1:0] sy1_m, sy2_m, prs_m;
  int            run_m [NK];
  int            held_m [NK];
  logic [NK-1:0] exp_pp, exp_rp, exp_lp;

  task automatic model_edge();
    logic [NK-1:0] s;
    exp_pp = '0; exp_rp = '0; exp_lp = '0;
    if (rst) begin
      sy1_m = '1; sy2_m = '1; prs_m = '0;
      for (int k = 0; k < NK; k++) begin run_m[k] = 0; held_m[k] = 0; end
      return;
    end
    s = ~sy2_m;
    sy2_m = sy1_m;
    sy1_m = bus.KEY;
    for (int k = 0; k < NK; k++) begin
      if (prs_m[k] && run_m[k] == 0) begin
        if (held_m[k] == L - 1) exp_lp[k] = 1'b1;
        if (held_m[k] < L) held_m[k]++;
      end
      if (s[k] != prs_m[k]) begin
        run_m[k]++;
        if (run_m[k] == S + 1) begin
          prs_m[k]  = s[k];
          run_m[k]  = 0;
          held_m[k] = 0;
          if (s[k]) exp_pp[k] = 1'b1;
          else      exp_rp[k] = 1'b1;
        end
      end else begin
        run_m[k] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%b exp=%b at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // One clock: update the model on the edge, compare all outputs 1ns later.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("pressed", bus.pressed, prs_m);
    chk("press_pulse", bus.press_pulse, exp_pp);
    chk("release_pulse", bus.release_pulse, exp_rp);
    chk("long_pulse", bus.long_pulse, exp_lp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int found, cnt, bad, p_cyc, l_cyc;
    int rem [NK];
    logic [NK-1:0] kv;

    // 1. reset with all keys held
    bus.KEY = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outputs", bus.pressed | bus.press_pulse | bus.release_pulse | bus.long_pulse, '0);
    end
    rst = 1'b0;
    found = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (found < 0 && bus.press_pulse != '0) found = i;
    end
    chk_int("reset_to_press_latency", found, 6);
    bus.KEY = '1;
    idle(12);

    // 2. clean press on key 0
    bus.KEY[0] = 1'b0;
    idle(7);
    chk("clean_press_pulse", bus.press_pulse, 4'b0001);
    chk("clean_press_level", bus.pressed, 4'b0001);
    step();
    chk("clean_press_pulse_end", bus.press_pulse, 4'b0000);
    bus.KEY[0] = 1'b1;
    idle(12);

    // 3. bounce on key 1
    bus.KEY[1] = 1'b0; idle(3);
    bus.KEY[1] = 1'b1; idle(1);
    bus.KEY[1] = 1'b0;
    found = -1; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.press_pulse[1]) begin cnt++; if (found < 0) found = i; end
    end
    chk_int("bounce_press_latency", found, 6);
    chk_int("bounce_press_count", cnt, 1);
    bus.KEY[1] = 1'b1;
    idle(12);

    // 4. long hold on key 2, then release
    bus.KEY[2] = 1'b0;
    p_cyc = -1; l_cyc = -1; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.press_pulse[2]) p_cyc = cyc;
      if (bus.long_pulse[2]) begin cnt++; l_cyc = cyc; end
    end
    chk_int("long_after_press", l_cyc - p_cyc, 20);
    chk_int("long_count", cnt, 1);
    bus.KEY[2] = 1'b1;
    found = -1; bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (found < 0 && bus.release_pulse[2]) begin
        found = i;
        if (bus.pressed[2] !== 1'b0) bad++;
      end
    end
    chk_int("release_latency", found, 6);
    chk_int("release_level_with_pulse", bad, 0);
    idle(4);

    // 5. release bounce on key 3 while pressed
    bus.KEY[3] = 1'b0;
    idle(7);
    p_cyc = cyc;
    chk("rb_pressed", bus.press_pulse, 4'b1000);
    idle(3);
    bus.KEY[3] = 1'b1; idle(2);
    bus.KEY[3] = 1'b0;
    l_cyc = -1; cnt = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.press_pulse[3] || bus.release_pulse[3]) cnt++;
      if (!bus.pressed[3]) bad++;
      if (bus.long_pulse[3]) l_cyc = cyc;
    end
    chk_int("rb_no_pulses", cnt, 0);
    chk_int("rb_level_held", bad, 0);
    chk_int("rb_long_extended", l_cyc - p_cyc, 22);
    bus.KEY[3] = 1'b1;
    idle(12);

    // 6. simultaneous press, then reset mid-debounce
    bus.KEY = '0;
    found = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (found < 0 && bus.press_pulse == 4'b1111) found = i;
    end
    chk_int("simul_press", found, 6);
    bus.KEY = '1;
    idle(12);
    bus.KEY = '0;
    idle(4);
    rst = 1'b1; step();
    rst = 1'b0;
    found = -1; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.press_pulse != '0) begin cnt++; if (found < 0) found = i; end
    end
    chk_int("reset_restart_latency", found, 6);
    chk_int("reset_restart_count", cnt, 1);
    bus.KEY = '1;
    idle(12);

    // random phase: per-key holds mixing glitches, accepted changes and long holds
    for (int k = 0; k < NK; k++) rem[k] = 0;
    for (int i = 0; i < 1500; i++) begin
      kv = bus.KEY;
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          kv[k] = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 3))
            0:       rem[k] = $urandom_range(1, 3);
            1:       rem[k] = $urandom_range(4, 7);
            2:       rem[k] = $urandom_range(8, 14);
            default: rem[k] = $urandom_range(22, 35);
          endcase
        end
        rem[k]--;
      end
      bus.KEY = kv;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
